// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// State enum, strobe bundle, bus widths and parameter defaults.
package sram_arb_pkg;

   localparam int SRAM_AW          = 18;
   localparam int SRAM_DW          = 16;
   localparam int RD_WAIT_DEF      = 1;
   localparam int WR_MAX_BURST_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      WR_SET,
      WR_STB,
      RD_SET
   } state_t;

   // Active-low strobes plus the write-data tristate enable.
   typedef struct packed {
      logic ce;
      logic we;
      logic oe;
      logic dq_oe;
   } pins_t;

   // Pin levels for the cycle spent in state s.
   function automatic pins_t pins_of(state_t s);
      pins_t p;
      case (s)
         WR_SET:  p = '{ce: 1'b0, we: 1'b1, oe: 1'b1, dq_oe: 1'b1};
         WR_STB:  p = '{ce: 1'b0, we: 1'b0, oe: 1'b1, dq_oe: 1'b1};
         RD_SET:  p = '{ce: 1'b0, we: 1'b1, oe: 1'b0, dq_oe: 1'b0};
         default: p = '{ce: 1'b1, we: 1'b1, oe: 1'b1, dq_oe: 1'b0};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/sram_arb_sel.sv
// Read/write grant selection with write-starvation counter.
// Ports: clk, rst_n, arb_en, wr_req, rd_req -> gnt_wr, gnt_rd.
module sram_arb_sel
   import sram_arb_pkg::*;
#(
   parameter int WR_MAX_BURST = WR_MAX_BURST_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic arb_en,
   input  logic wr_req,
   input  logic rd_req,
   output logic gnt_wr,
   output logic gnt_rd
);

   localparam int CW = $clog2(WR_MAX_BURST + 1);

   logic [CW-1:0] cnt;
   logic          starved;

   assign starved = (cnt == CW'(WR_MAX_BURST));

   // Reads win ties until the pending write has been passed over
   // WR_MAX_BURST times.
   assign gnt_wr = wr_req & (~rd_req | starved);
   assign gnt_rd = rd_req & ~gnt_wr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!wr_req || (arb_en && gnt_wr)) begin
         cnt <= '0;
      end else if (arb_en && gnt_rd && !starved) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/sram_arb.sv
// Two-port (pixel write / line read) arbiter for an async SRAM.
// Ports: CLK_100M, RST_N, WR_*/RD_* requesters, SRAM_* pins, BUSY.
module sram_arb
   import sram_arb_pkg::*;
#(
   parameter int RD_WAIT      = RD_WAIT_DEF,
   parameter int WR_MAX_BURST = WR_MAX_BURST_DEF
) (
   input  logic               CLK_100M,
   input  logic               RST_N,
   input  logic               WR_REQ,
   input  logic [SRAM_AW-1:0] WR_ADDR,
   input  logic [SRAM_DW-1:0] WR_DATA,
   output logic               WR_ACK,
   input  logic               RD_REQ,
   input  logic [SRAM_AW-1:0] RD_ADDR,
   output logic               RD_ACK,
   output logic               RD_DVLD,
   output logic [SRAM_DW-1:0] RD_DATA,
   output logic               SRAM_CE,
   output logic               SRAM_WE,
   output logic               SRAM_OE,
   output logic               SRAM_UB,
   output logic               SRAM_LB,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [SRAM_DW-1:0] SRAM_DQ_O,
   output logic               SRAM_DQ_OE,
   input  logic [SRAM_DW-1:0] SRAM_DQ_I,
   output logic               BUSY
);

   state_t     state;
   pins_t      pins;
   logic [2:0] rd_cnt;
   logic       rd_last;
   logic       rd_cap;
   logic       arb_en;
   logic       gnt_wr;
   logic       gnt_rd;

   assign rd_last = (state == RD_SET) && (rd_cnt == 3'(RD_WAIT));

   // Last cycle of every transaction doubles as an arbitration slot.
   assign arb_en = (state == IDLE) || (state == WR_STB) || rd_last;

   sram_arb_sel #(
      .WR_MAX_BURST(WR_MAX_BURST)
   ) u_sel (
      .clk   (CLK_100M),
      .rst_n (RST_N),
      .arb_en(arb_en),
      .wr_req(WR_REQ),
      .rd_req(RD_REQ),
      .gnt_wr(gnt_wr),
      .gnt_rd(gnt_rd)
   );

   assign SRAM_CE    = pins.ce;
   assign SRAM_WE    = pins.we;
   assign SRAM_OE    = pins.oe;
   assign SRAM_DQ_OE = pins.dq_oe;
   assign SRAM_UB    = pins.ce;
   assign SRAM_LB    = pins.ce;

   always_ff @(posedge CLK_100M) begin
      if (!RST_N) begin
         state     <= IDLE;
         pins      <= pins_of(IDLE);
         rd_cnt    <= '0;
         rd_cap    <= 1'b0;
         SRAM_ADDR <= '0;
         SRAM_DQ_O <= '0;
         RD_DATA   <= '0;
         WR_ACK    <= 1'b0;
         RD_ACK    <= 1'b0;
         RD_DVLD   <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         WR_ACK  <= 1'b0;
         RD_ACK  <= 1'b0;
         rd_cap  <= rd_last;
         RD_DVLD <= rd_cap;
         if (rd_last) begin
            RD_DATA <= SRAM_DQ_I;
         end
         if (arb_en && gnt_wr) begin
            state     <= WR_SET;
            pins      <= pins_of(WR_SET);
            SRAM_ADDR <= WR_ADDR;
            SRAM_DQ_O <= WR_DATA;
            WR_ACK    <= 1'b1;
            BUSY      <= 1'b1;
         end else if (arb_en && gnt_rd) begin
            state     <= RD_SET;
            pins      <= pins_of(RD_SET);
            rd_cnt    <= '0;
            SRAM_ADDR <= RD_ADDR;
            RD_ACK    <= 1'b1;
            BUSY      <= 1'b1;
         end else if (state == WR_SET) begin
            state <= WR_STB;
            pins  <= pins_of(WR_STB);
         end else if (state == RD_SET && !rd_last) begin
            rd_cnt <= rd_cnt + 3'd1;
         end else begin
            state <= IDLE;
            pins  <= pins_of(IDLE);
            BUSY  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sram_arb.sv
// Directed self-checking bench for sram_arb with a behavioural SRAM.
// Scenarios: reset, write, read, back-to-back, starvation, abort.
module tb_sram_arb;

   logic        CLK_100M = 1'b0;
   logic        RST_N = 1'b0;
   logic        WR_REQ = 1'b0;
   logic [17:0] WR_ADDR = '0;
   logic [15:0] WR_DATA = '0;
   logic        WR_ACK;
   logic        RD_REQ = 1'b0;
   logic [17:0] RD_ADDR = '0;
   logic        RD_ACK;
   logic        RD_DVLD;
   logic [15:0] RD_DATA;
   logic        SRAM_CE, SRAM_WE, SRAM_OE, SRAM_UB, SRAM_LB;
   logic [17:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_O;
   logic        SRAM_DQ_OE;
   logic [15:0] SRAM_DQ_I;
   logic        BUSY;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:262143];

   always #5 CLK_100M = ~CLK_100M;

   always @(posedge CLK_100M)
      if (!SRAM_CE && !SRAM_WE) mem[SRAM_ADDR] <= SRAM_DQ_O;

   assign SRAM_DQ_I = (!SRAM_CE && !SRAM_OE) ? mem[SRAM_ADDR] : 16'h0;

   sram_arb dut (
      .CLK_100M  (CLK_100M),
      .RST_N     (RST_N),
      .WR_REQ    (WR_REQ),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .WR_ACK    (WR_ACK),
      .RD_REQ    (RD_REQ),
      .RD_ADDR   (RD_ADDR),
      .RD_ACK    (RD_ACK),
      .RD_DVLD   (RD_DVLD),
      .RD_DATA   (RD_DATA),
      .SRAM_CE   (SRAM_CE),
      .SRAM_WE   (SRAM_WE),
      .SRAM_OE   (SRAM_OE),
      .SRAM_UB   (SRAM_UB),
      .SRAM_LB   (SRAM_LB),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ_O (SRAM_DQ_O),
      .SRAM_DQ_OE(SRAM_DQ_OE),
      .SRAM_DQ_I (SRAM_DQ_I),
      .BUSY      (BUSY)
   );

   task automatic tick;
      @(posedge CLK_100M);
      #1;
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      tick();
      tick();
      checks++;
      if ({SRAM_CE, SRAM_WE, SRAM_OE, SRAM_UB, SRAM_LB, SRAM_DQ_OE} !== 6'b111110) begin
         errors++;
         $display("FAIL reset_pins: got %b want 111110",
                  {SRAM_CE, SRAM_WE, SRAM_OE, SRAM_UB, SRAM_LB, SRAM_DQ_OE});
      end
      checks++;
      if ({SRAM_ADDR, SRAM_DQ_O, RD_DATA} !== 50'h0) begin
         errors++;
         $display("FAIL reset_regs: addr %h dq %h rd %h want 0", SRAM_ADDR, SRAM_DQ_O, RD_DATA);
      end
      checks++;
      if ({WR_ACK, RD_ACK, RD_DVLD, BUSY} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000", {WR_ACK, RD_ACK, RD_DVLD, BUSY});
      end
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_write;
      WR_REQ = 1'b1;
      WR_ADDR = 18'h00010;
      WR_DATA = 16'hA5A5;
      tick();
      checks++;
      if ({WR_ACK, SRAM_CE, SRAM_OE, SRAM_WE, SRAM_DQ_OE, SRAM_UB, BUSY} !== 7'b1011101) begin
         errors++;
         $display("FAIL wr_set: got %b want 1011101",
                  {WR_ACK, SRAM_CE, SRAM_OE, SRAM_WE, SRAM_DQ_OE, SRAM_UB, BUSY});
      end
      checks++;
      if (SRAM_ADDR !== 18'h00010 || SRAM_DQ_O !== 16'hA5A5) begin
         errors++;
         $display("FAIL wr_bus: addr %h dq %h want 00010 a5a5", SRAM_ADDR, SRAM_DQ_O);
      end
      WR_REQ = 1'b0;
      tick();
      checks++;
      if ({WR_ACK, SRAM_CE, SRAM_WE, SRAM_DQ_OE} !== 4'b0001) begin
         errors++;
         $display("FAIL wr_stb: got %b want 0001", {WR_ACK, SRAM_CE, SRAM_WE, SRAM_DQ_OE});
      end
      tick();
      checks++;
      if ({SRAM_CE, SRAM_WE, SRAM_DQ_OE, BUSY} !== 4'b1100) begin
         errors++;
         $display("FAIL wr_idle: got %b want 1100", {SRAM_CE, SRAM_WE, SRAM_DQ_OE, BUSY});
      end
      checks++;
      if (mem[18'h00010] !== 16'hA5A5) begin
         errors++;
         $display("FAIL wr_mem: got %h want a5a5", mem[18'h00010]);
      end
   endtask

   task automatic test_read;
      RD_REQ = 1'b1;
      RD_ADDR = 18'h00010;
      tick();
      checks++;
      if ({RD_ACK, SRAM_CE, SRAM_OE, SRAM_DQ_OE, SRAM_ADDR} !== {4'b1000, 18'h00010}) begin
         errors++;
         $display("FAIL rd_c1: ack %b ce %b oe %b dqoe %b addr %h want 1 0 0 0 00010",
                  RD_ACK, SRAM_CE, SRAM_OE, SRAM_DQ_OE, SRAM_ADDR);
      end
      RD_REQ = 1'b0;
      tick();
      checks++;
      if ({RD_ACK, SRAM_OE, RD_DVLD, BUSY} !== 4'b0001) begin
         errors++;
         $display("FAIL rd_c2: got %b want 0001", {RD_ACK, SRAM_OE, RD_DVLD, BUSY});
      end
      tick();
      checks++;
      if ({SRAM_OE, RD_DVLD, RD_DATA} !== {2'b10, 16'hA5A5}) begin
         errors++;
         $display("FAIL rd_cap: oe %b dvld %b data %h want 1 0 a5a5", SRAM_OE, RD_DVLD, RD_DATA);
      end
      tick();
      checks++;
      if (RD_DVLD !== 1'b1 || RD_DATA !== 16'hA5A5) begin
         errors++;
         $display("FAIL rd_dvld: dvld %b data %h want 1 a5a5", RD_DVLD, RD_DATA);
      end
      tick();
      checks++;
      if (RD_DVLD !== 1'b0 || RD_DATA !== 16'hA5A5) begin
         errors++;
         $display("FAIL rd_hold: dvld %b data %h want 0 a5a5", RD_DVLD, RD_DATA);
      end
   endtask

   task automatic test_back_to_back;
      WR_REQ = 1'b1;
      WR_ADDR = 18'h3FFFF;
      WR_DATA = 16'h1234;
      tick();
      checks++;
      if (WR_ACK !== 1'b1 || SRAM_ADDR !== 18'h3FFFF) begin
         errors++;
         $display("FAIL b2b_ack1: ack %b addr %h want 1 3ffff", WR_ACK, SRAM_ADDR);
      end
      tick();
      WR_ADDR = 18'h00000;
      WR_DATA = 16'h5678;
      checks++;
      if (SRAM_WE !== 1'b0) begin
         errors++;
         $display("FAIL b2b_we1: got %b want 0", SRAM_WE);
      end
      tick();
      checks++;
      if ({WR_ACK, SRAM_CE, SRAM_WE, BUSY} !== 4'b1011 || SRAM_ADDR !== 18'h0) begin
         errors++;
         $display("FAIL b2b_ack2: flags %b addr %h want 1011 00000",
                  {WR_ACK, SRAM_CE, SRAM_WE, BUSY}, SRAM_ADDR);
      end
      WR_REQ = 1'b0;
      tick();
      checks++;
      if (SRAM_WE !== 1'b0 || SRAM_DQ_O !== 16'h5678) begin
         errors++;
         $display("FAIL b2b_we2: we %b dq %h want 0 5678", SRAM_WE, SRAM_DQ_O);
      end
      tick();
      checks++;
      if (mem[18'h3FFFF] !== 16'h1234 || mem[18'h00000] !== 16'h5678) begin
         errors++;
         $display("FAIL b2b_mem: got %h %h want 1234 5678", mem[18'h3FFFF], mem[18'h00000]);
      end
   endtask

   task automatic test_starvation;
      int n;
      n = 0;
      RD_ADDR = 18'h00010;
      WR_ADDR = 18'h00020;
      WR_DATA = 16'h0F0F;
      RD_REQ = 1'b1;
      WR_REQ = 1'b1;
      for (int c = 0; c < 200 && n < 18; c++) begin
         tick();
         checks++;
         if ((SRAM_DQ_OE && !SRAM_OE) || SRAM_UB !== SRAM_CE) begin
            errors++;
            $display("FAIL starve_pins: dqoe %b oe %b ub %b ce %b", SRAM_DQ_OE, SRAM_OE, SRAM_UB, SRAM_CE);
         end
         if (WR_ACK || RD_ACK) begin
            checks++;
            if ({WR_ACK, RD_ACK} !== ((n % 9 == 8) ? 2'b10 : 2'b01)) begin
               errors++;
               $display("FAIL starve_grant %0d: wr %b rd %b want write=%0d", n, WR_ACK, RD_ACK, n % 9 == 8);
            end
            n++;
         end
      end
      checks++;
      if (n != 18) begin
         errors++;
         $display("FAIL starve_count: got %0d grants want 18", n);
      end
      RD_REQ = 1'b0;
      WR_REQ = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      checks++;
      if (BUSY !== 1'b0 || mem[18'h00020] !== 16'h0F0F) begin
         errors++;
         $display("FAIL starve_end: busy %b mem %h want 0 0f0f", BUSY, mem[18'h00020]);
      end
   endtask

   task automatic test_reset_mid_read;
      int dv;
      RD_REQ = 1'b1;
      RD_ADDR = 18'h00010;
      tick();
      RD_REQ = 1'b0;
      RST_N = 1'b0;
      tick();
      checks++;
      if ({SRAM_CE, SRAM_OE, SRAM_DQ_OE, BUSY, RD_ACK, RD_DVLD} !== 6'b110000
          || SRAM_ADDR !== 18'h0 || RD_DATA !== 16'h0) begin
         errors++;
         $display("FAIL abort_reset: flags %b addr %h data %h want 110000 0 0",
                  {SRAM_CE, SRAM_OE, SRAM_DQ_OE, BUSY, RD_ACK, RD_DVLD}, SRAM_ADDR, RD_DATA);
      end
      RST_N = 1'b1;
      dv = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (RD_DVLD) dv++;
      end
      checks++;
      if (dv != 0) begin
         errors++;
         $display("FAIL abort_dvld: got %0d pulses want 0", dv);
      end
      RD_REQ = 1'b1;
      RD_ADDR = 18'h3FFFF;
      tick();
      checks++;
      if (RD_ACK !== 1'b1) begin
         errors++;
         $display("FAIL abort_rd_ack: got %b want 1", RD_ACK);
      end
      RD_REQ = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (RD_DVLD !== 1'b1 || RD_DATA !== 16'h1234) begin
         errors++;
         $display("FAIL abort_rd_data: dvld %b data %h want 1 1234", RD_DVLD, RD_DATA);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_starvation();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter RD_WAIT, default 1, extra read-strobe cycles before data capture; legal range 1..4.
REQ-002 Parameter WR_MAX_BURST, default 8, consecutive read grants allowed while a write is pending.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 CLK_100M  in  1  sole clock.
REQ-005 RST_N  in  1  synchronous reset, active-low.
REQ-006 WR_REQ / WR_ADDR / WR_DATA  in  1/18/16  pixel-write request, address, data.
REQ-007 WR_ACK  out  1  one-cycle pulse: write accepted.
REQ-008 RD_REQ / RD_ADDR  in  1/18  line-fetch read request and address.
REQ-009 RD_ACK  out  1  one-cycle pulse: read accepted.
REQ-010 RD_DVLD / RD_DATA  out  1/16  read data valid pulse and data.
REQ-011 SRAM_CE, SRAM_WE, SRAM_OE, SRAM_UB, SRAM_LB  out  1 each  active-low SRAM strobes.
REQ-012 SRAM_ADDR / SRAM_DQ_O / SRAM_DQ_OE / SRAM_DQ_I  out/out/out/in  18/16/1/16  SRAM address, write data, tristate enable, read data (tristate buffer lives in the top level).
REQ-013 BUSY  out  1  high while a transaction is in flight.

Function
REQ-014 FSM states SHALL be IDLE, WR_SET, WR_STB, RD_SET; every transaction lasts at least 2 cycles.
REQ-015 Arbitration SHALL occur in IDLE and on the last cycle of each transaction, so back-to-back transactions have no gap.
REQ-016 Read SHALL win when both requests are active, unless the starvation counter equals WR_MAX_BURST with WR_REQ high; in that case write wins.
REQ-017 The starvation counter SHALL increment on each read grant while WR_REQ is high, clear on a write grant or when WR_REQ is low, and saturate at WR_MAX_BURST.
REQ-018 ADDR/DATA SHALL be registered on the grant edge; the ACK SHALL be high for exactly the first cycle of the granted transaction.
REQ-019 The requester SHALL hold REQ/ADDR/DATA stable until ACK; the requester MAY present the next request on the cycle after ACK.
REQ-020 WR_SET (1 cycle) SHALL drive CE=0, OE=1, WE=1, DQ_OE=1, with address and data valid.
REQ-021 WR_STB (1 cycle) SHALL additionally drive WE=0; WE=1 SHALL hold whenever address or data change.
REQ-022 RD_SET SHALL last 1+RD_WAIT cycles with CE=0, OE=0, WE=1, DQ_OE=0.
REQ-023 On the last RD_SET edge, SRAM_DQ_I SHALL be captured into RD_DATA, and RD_DVLD SHALL pulse the following cycle.
REQ-024 Read latency is grant edge to RD_DVLD = RD_WAIT+2 cycles.
REQ-025 RD_DATA SHALL hold its value until the next capture.
REQ-026 UB=LB=0 whenever CE=0.
REQ-027 In IDLE with no request: CE=OE=WE=UB=LB=1 and DQ_OE=0.
REQ-028 DQ_OE SHALL never be 1 in the same cycle as OE=0.
REQ-029 BUSY SHALL be 0 only in IDLE.
REQ-030 SRAM_ADDR SHALL use full 18-bit addressing with no wrap logic; the requester owns address generation.

Reset
REQ-031 While RST_N=0 at a clock edge: state=IDLE; CE/WE/OE/UB/LB=1; DQ_OE=0; SRAM_ADDR, SRAM_DQ_O and RD_DATA=0; WR_ACK, RD_ACK, RD_DVLD and BUSY=0; starvation counter=0.
REQ-032 A reset mid-transaction SHALL abort the transaction; no ACK or RD_DVLD SHALL be issued for the aborted transaction after the reset.

Structure
REQ-033 Shared package sram_arb_pkg SHALL hold the state enum, SRAM_AW=18, SRAM_DW=16, and the RD_WAIT/WR_MAX_BURST defaults.
REQ-034 The grant and starvation logic SHALL be one sub-module, sram_arb_sel; the FSM and pin drive remain in sram_arb.

Verification
REQ-035 Single write WR_ADDR=0x00010, WR_DATA=0xA5A5 -> WR_ACK one cycle after grant; WE=0 only in the 2nd cycle; DQ_OE=1 for both cycles; SRAM model holds 0xA5A5.
REQ-036 Read from 0x00010 with RD_WAIT=1 -> OE=0 for 2 cycles; RD_DVLD 3 cycles after grant; RD_DATA=0xA5A5.
REQ-037 RD_REQ and WR_REQ held high continuously, WR_MAX_BURST=8 -> pattern of 8 reads then 1 write repeats; no write waits more than 8 read grants.
REQ-038 Back-to-back writes to 0x3FFFF then 0x00000 -> no idle cycle between them; both stored; WE pulses separated by WE=1.
REQ-039 RST_N=0 asserted during RD_SET -> all outputs at reset values next edge; no RD_DVLD; a subsequent read works normally.
REQ-040 Random mixed traffic, 10k transactions -> scoreboard matches; DQ_OE and OE=0 are never high in the same cycle.
